bus_fifo_port: RTL and testbench

Memory-mapped FIFO peripheral that answers CPU bus accesses (`bus_addr`/`bus_data`/`read`/`write`) as a responder, in parallel with data memory. CPU writes push words into a TX FIFO drained by an external valid/ready stream. An external producer fills an RX FIFO that the CPU pops by reading. It gives the monocycle CPU a buffered I/O channel without stalling the bus.

---
 rtl/bus_fifo_port.sv | 216 +++++++++++++++++++++
 tb/tb_bus_fifo_port.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_fifo_port.sv
// bus_fifo_port
// Memory-mapped FIFO peripheral that sits on the CPU bus next to data memory.
// CPU writes to TXDATA feed an outgoing valid/ready stream, and an incoming
// valid/ready stream fills an RX FIFO that the CPU drains by reading RXDATA.
// Window: BASE+0 TXDATA, BASE+1 RXDATA, BASE+2 STATUS, BASE+3 THRESH.
// Optional feature: define BUS_FIFO_IRQ_EN to get a writable THRESH register
// and a registered irq output that fires when rx_count >= THRESH (THRESH != 0).
module bus_fifo_port #(
   parameter int                    ADDR_WIDTH = 20,
   parameter int                    DATA_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 20'hFFF00,
   parameter int                    DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] bus_addr,
   inout  wire  [DATA_WIDTH-1:0] bus_data,
   input  logic                  read,
   input  logic                  write,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready
`ifdef BUS_FIFO_IRQ_EN
   ,
   output logic                  irq
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic                  hit;
   logic [1:0]            offset;
   logic                  rd_acc;
   logic                  wr_acc;

   logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
   logic [PW-1:0]         tx_wr_ptr;
   logic [PW-1:0]         tx_rd_ptr;
   logic [CW-1:0]         tx_count;
   logic [CW-1:0]         tx_count_nxt;
   logic                  tx_full;
   logic                  tx_empty;

   logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
   logic [PW-1:0]         rx_wr_ptr;
   logic [PW-1:0]         rx_rd_ptr;
   logic [CW-1:0]         rx_count;
   logic [CW-1:0]         rx_count_nxt;
   logic                  rx_full;
   logic                  rx_empty;

   logic                  tx_wr_hit;
   logic                  tx_push;
   logic                  tx_pop;
   logic                  rx_rd_hit;
   logic                  rx_push;
   logic                  rx_pop;
   logic                  stat_wr;
   logic                  flush;
   logic                  ovf_set;
   logic                  ovf_clr;
   logic                  unf_set;
   logic                  unf_clr;
   logic                  tx_ovf;
   logic                  rx_unf;

   logic [DATA_WIDTH-1:0] status;
   logic [DATA_WIDTH-1:0] thresh_rd;
   logic [DATA_WIDTH-1:0] rd_data;

   // Address decode: a simultaneous read and write is treated as no access at all.
   assign hit    = (bus_addr[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]);
   assign offset = bus_addr[1:0];
   assign rd_acc = hit && read && !write;
   assign wr_acc = hit && write && !read;

   assign tx_full  = (tx_count == FULL_COUNT);
   assign tx_empty = (tx_count == '0);
   assign rx_full  = (rx_count == FULL_COUNT);
   assign rx_empty = (rx_count == '0);

   // Stream side: everything here comes from registered state only.
   assign out_valid = !tx_empty;
   assign out_data  = tx_mem[tx_rd_ptr];
   assign in_ready  = reset && !rx_full;

   // A pop in the same cycle frees a slot, so a full TX FIFO can still accept a push.
   assign tx_pop    = out_valid && out_ready;
   assign tx_wr_hit = wr_acc && (offset == 2'd0);
   assign tx_push   = tx_wr_hit && (!tx_full || tx_pop);
   assign ovf_set   = tx_wr_hit && tx_full && !tx_pop;

   assign rx_push   = in_valid && in_ready;
   assign rx_rd_hit = rd_acc && (offset == 2'd1);
   assign rx_pop    = rx_rd_hit && !rx_empty;
   assign unf_set   = rx_rd_hit && rx_empty;

   assign stat_wr = wr_acc && (offset == 2'd2);
   assign flush   = stat_wr && bus_data[15];
   assign ovf_clr = stat_wr && bus_data[4];
   assign unf_clr = stat_wr && bus_data[5];

   assign status = DATA_WIDTH'({8'(rx_count), 2'b00, rx_unf, tx_ovf,
                                rx_empty, rx_full, tx_empty, tx_full});

   // Next occupancy of both FIFOs; a flush overrides any push or pop in the same cycle.
   always_comb begin
      tx_count_nxt = tx_count;
      rx_count_nxt = rx_count;
      if (flush) begin
         tx_count_nxt = '0;
         rx_count_nxt = '0;
      end else begin
         if (tx_push && !tx_pop) begin
            tx_count_nxt = tx_count + CW'(1);
         end else if (tx_pop && !tx_push) begin
            tx_count_nxt = tx_count - CW'(1);
         end
         if (rx_push && !rx_pop) begin
            rx_count_nxt = rx_count + CW'(1);
         end else if (rx_pop && !rx_push) begin
            rx_count_nxt = rx_count - CW'(1);
         end
      end
   end

   // FIFO pointers and counts; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         tx_count  <= '0;
         rx_count  <= '0;
      end else begin
         tx_count <= tx_count_nxt;
         rx_count <= rx_count_nxt;
         if (flush) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
         end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
         end
      end
   end

   // Storage arrays carry no reset; stale words are unreachable once the pointers move.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= bus_data;
      if (rx_push) rx_mem[rx_wr_ptr] <= in_data;
   end

   // Sticky error flags; a write-1-to-clear beats a same-cycle set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_ovf <= 1'b0;
         rx_unf <= 1'b0;
      end else begin
         if (ovf_clr)      tx_ovf <= 1'b0;
         else if (ovf_set) tx_ovf <= 1'b1;
         if (unf_clr)      rx_unf <= 1'b0;
         else if (unf_set) rx_unf <= 1'b1;
      end
   end

`ifdef BUS_FIFO_IRQ_EN
   logic [CW-1:0] thresh;
   logic [CW-1:0] thresh_nxt;

   // THRESH only keeps the bits wide enough to hold a full count.
   always_comb begin
      thresh_nxt = thresh;
      if (wr_acc && (offset == 2'd3)) thresh_nxt = bus_data[CW-1:0];
   end

   // THRESH register and irq, both computed from next state so irq lines up with STATUS.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         thresh <= CW'(1);
         irq    <= 1'b0;
      end else begin
         thresh <= thresh_nxt;
         irq    <= (thresh_nxt != '0) && (rx_count_nxt >= thresh_nxt);
      end
   end

   assign thresh_rd = DATA_WIDTH'(thresh);
`else
   assign thresh_rd = '0;
`endif

   // Read mux: combinational so the CPU sees data within the same cycle.
   always_comb begin
      rd_data = '0;
      case (offset)
         2'd1:    if (!rx_empty) rd_data = rx_mem[rx_rd_ptr];
         2'd2:    rd_data = status;
         2'd3:    rd_data = thresh_rd;
         default: rd_data = '0;
      endcase
   end

   assign bus_data = (rd_acc && reset) ? rd_data : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_fifo_port.sv
// tb_bus_fifo_port
// Scoreboard bench for bus_fifo_port: the stimulus task keeps a queue-based
// model of both FIFOs and the stickies, pushes expected read data and expected
// TX stream words, and a negedge monitor pops and compares them.
// Define BUS_FIFO_IRQ_EN to also exercise THRESH and irq.
module tb_bus_fifo_port;

   localparam int DEPTH = 16;
   localparam logic [19:0] BASE = 20'hFFF00;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] bus_addr;
   logic        read;
   logic        write;
   logic        tb_drive;
   logic [15:0] tb_wdata;
   wire  [15:0] bus_data;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
`ifdef BUS_FIFO_IRQ_EN
   logic        irq;
`endif

   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;

   int          tx_cnt = 0;
   logic [15:0] exp_tx[$];
   logic [15:0] exp_rd[$];
   logic [15:0] rx_q[$];
   bit          m_ovf = 1'b0;
   bit          m_unf = 1'b0;
   int          m_thresh = 1;

   assign bus_data = tb_drive ? tb_wdata : 16'bz;

   always #5 clk = ~clk;

   bus_fifo_port dut (
      .clk       (clk),
      .reset     (reset),
      .bus_addr  (bus_addr),
      .bus_data  (bus_data),
      .read      (read),
      .write     (write),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready)
`ifdef BUS_FIFO_IRQ_EN
      ,
      .irq       (irq)
`endif
   );

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One bus/stream cycle: drive inputs, predict responses, advance the model, step the clock.
   task automatic apply_stimulus(input bit rd, input bit wr, input logic [19:0] addr,
                                 input logic [15:0] wdata, input bit ordy,
                                 input bit ivld, input logic [15:0] idata);
      bit          hit, r, w, tx_pop, tx_full, flush;
      logic [1:0]  off;
      logic [15:0] ev;
      int          n;
      hit   = (addr[19:2] == BASE[19:2]);
      off   = addr[1:0];
      r     = hit && rd && !wr;
      w     = hit && wr && !rd;
      flush = w && (off == 2'd2) && wdata[15];
      if (flush) ordy = 1'b0;
      bus_addr  = addr;
      read      = rd;
      write     = wr;
      tb_drive  = wr;
      tb_wdata  = wdata;
      out_ready = ordy;
      in_valid  = ivld;
      in_data   = idata;
      n = rx_q.size();
      if (r) begin
         case (off)
            2'd0: ev = 16'h0000;
            2'd1: ev = (n > 0) ? rx_q[0] : 16'h0000;
            2'd2: ev = {8'(n), 2'b00, m_unf, m_ovf, n == 0, n == DEPTH, tx_cnt == 0, tx_cnt == DEPTH};
`ifdef BUS_FIFO_IRQ_EN
            default: ev = 16'(m_thresh);
`else
            default: ev = 16'h0000;
`endif
         endcase
         exp_rd.push_back(ev);
      end
      tx_pop  = (tx_cnt > 0) && ordy;
      tx_full = (tx_cnt == DEPTH);
      if (w && off == 2'd2 && wdata[4]) m_ovf = 1'b0;
      else if (w && off == 2'd0 && tx_full && !tx_pop) m_ovf = 1'b1;
      if (w && off == 2'd2 && wdata[5]) m_unf = 1'b0;
      else if (r && off == 2'd1 && n == 0) m_unf = 1'b1;
`ifdef BUS_FIFO_IRQ_EN
      if (w && off == 2'd3) m_thresh = int'(wdata[4:0]);
`endif
      if (flush) begin
         tx_cnt = 0;
         exp_tx.delete();
         rx_q.delete();
      end else begin
         if (tx_pop) tx_cnt--;
         if (w && off == 2'd0 && !(tx_full && !tx_pop)) begin
            tx_cnt++;
            exp_tx.push_back(wdata);
         end
         if (r && off == 2'd1 && n > 0) void'(rx_q.pop_front());
         if (ivld && n < DEPTH) rx_q.push_back(idata);
      end
      @(posedge clk);
      #1;
      check_output("out_valid", 32'(out_valid), 32'(tx_cnt > 0));
      check_output("in_ready", 32'(in_ready), 32'(rx_q.size() < DEPTH));
`ifdef BUS_FIFO_IRQ_EN
      check_output("irq", 32'(irq), 32'((m_thresh != 0) && (rx_q.size() >= m_thresh)));
`endif
   endtask

   task automatic bus_write(input int off, input logic [15:0] data, input bit ordy);
      apply_stimulus(1'b0, 1'b1, BASE + 20'(off), data, ordy, 1'b0, 16'h0);
   endtask

   task automatic bus_read(input int off);
      apply_stimulus(1'b1, 1'b0, BASE + 20'(off), 16'h0, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic idle(input bit ordy, input bit ivld, input logic [15:0] idata);
      apply_stimulus(1'b0, 1'b0, BASE, 16'h0, ordy, ivld, idata);
   endtask

   // Monitor: compares bus read data and every accepted TX stream word against the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         if (read && !write && bus_addr[19:2] == BASE[19:2]) begin
            if (exp_rd.size() == 0) begin
               errors++;
               checks++;
               $display("[TB] FAIL bus_read: got %0h expected nothing", bus_data);
            end else begin
               check_output("bus_read", 32'(bus_data), 32'(exp_rd.pop_front()));
            end
         end
         if (out_valid && out_ready) begin
            if (exp_tx.size() == 0) begin
               errors++;
               checks++;
               $display("[TB] FAIL tx_word: got %0h expected no word", out_data);
            end else begin
               check_output("tx_word", 32'(out_data), 32'(exp_tx.pop_front()));
            end
         end
      end
   end

   // Directed scenarios followed by a randomized phase and a final drain.
   initial begin
      logic [15:0] wd;
      logic [19:0] ad;
      int          op;
      int          rdy_pct;
      int          vld_pct;
      reset     = 1'b0;
      read      = 1'b0;
      write     = 1'b0;
      tb_drive  = 1'b0;
      tb_wdata  = 16'h0;
      bus_addr  = 20'h0;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_in_ready", 32'(in_ready), 32'd0);
      check_output("reset_out_valid", 32'(out_valid), 32'd0);
      reset = 1'b1;
      #1;
      check_output("release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      bus_read(2);

      bus_write(0, 16'hA5A5, 1'b0);
      bus_write(0, 16'h1234, 1'b0);
      check_output("tx_head", 32'(out_data), 32'h0000A5A5);
      idle(1'b1, 1'b0, 16'h0);
      idle(1'b1, 1'b0, 16'h0);
      idle(1'b0, 1'b0, 16'h0);

      for (int i = 0; i < DEPTH; i++) bus_write(0, 16'h0100 + 16'(i), 1'b0);
      bus_write(0, 16'hDEAD, 1'b0);
      bus_read(2);
      bus_write(2, 16'h0010, 1'b0);
      bus_read(2);
      bus_write(0, 16'hBEEF, 1'b1);
      bus_read(2);
      apply_stimulus(1'b1, 1'b1, BASE, 16'h5555, 1'b0, 1'b0, 16'h0);
      bus_read(2);
      repeat (DEPTH + 2) idle(1'b1, 1'b0, 16'h0);

      for (int i = 1; i <= 3; i++) idle(1'b0, 1'b1, 16'(i));
      bus_read(2);
      repeat (4) bus_read(1);
      bus_read(2);
      bus_write(2, 16'h0020, 1'b0);
      bus_read(2);
      bus_read(3);

`ifdef BUS_FIFO_IRQ_EN
      bus_write(3, 16'hFFE2, 1'b0);
      bus_read(3);
      idle(1'b0, 1'b1, 16'h0AAA);
      idle(1'b0, 1'b1, 16'h0BBB);
      bus_read(1);
      bus_read(1);
`endif

      bus_write(0, 16'h7777, 1'b0);
      bus_write(0, 16'h8888, 1'b0);
      idle(1'b0, 1'b1, 16'h0C0C);
      apply_stimulus(1'b0, 1'b1, BASE + 20'd2, 16'h8000, 1'b1, 1'b1, 16'h0D0D);
      bus_read(2);
      idle(1'b1, 1'b0, 16'h0);

      for (int i = 0; i < 600; i++) begin
         rdy_pct = (i < 300) ? 15 : 70;
         vld_pct = (i < 300) ? 70 : 20;
         op = $urandom_range(0, 9);
         wd = 16'($urandom);
         if ($urandom_range(0, 19) != 0) wd[15] = 1'b0;
         ad = BASE + 20'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) ad = BASE ^ (20'd1 << $urandom_range(2, 19));
         apply_stimulus(op >= 3 && op <= 5 || op == 9, op >= 6, ad, wd,
                        $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 99) < vld_pct,
                        16'($urandom));
      end

      repeat (DEPTH + 2) idle(1'b1, 1'b0, 16'h0);
      repeat (DEPTH + 1) bus_read(1);
      bus_read(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
